// File: rtl/uart_pkg.sv
// Shared UART TX definitions: FSM state encoding, DATA_W limits and the parity helper.
package uart_pkg;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Zero-extending to DATA_W_MAX does not change the XOR reduction.
    function automatic logic par_calc(input logic [DATA_W_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic bit data_w_legal(input int w);
        return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// DEPTH x DATA_W synchronous FIFO with registered occupancy; async and sync clear.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [LVL_W-1:0]  count;
    logic              do_push, do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];
    assign level   = count;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_core.sv
// Buffered UART transmitter, LSB-first, 1/2 stop bits, paced by baud_tick.
// Optional parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              cfg_two_stop,
    input  logic              cfg_par_odd,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e         state, state_nxt;
    logic [DATA_W-1:0] shreg, rdata;
    logic [CNT_W-1:0]  bitcnt;
    logic              stopcnt, two_stop_l;
    logic              full, empty, load, stop_hold;

`ifdef UART_TX_PARITY_EN
    logic par_l;
`else
    logic unused_par_odd;
    assign unused_par_odd = cfg_par_odd;
`endif

    assign s_ready = !full;

    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .arst_n(arst_n),
        .rst   (rst),
        .push  (s_valid),
        .pop   (load),
        .wdata (s_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)  state <= IDLE;
        else if (rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (baud_tick) begin
            case (state)
                IDLE:  if (!empty) state_nxt = START;
                START: state_nxt = DATA;
                DATA: if (bitcnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
                PARITY: state_nxt = STOP;
`endif
                STOP:  if (!stop_hold) state_nxt = empty ? IDLE : START;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // load: a word leaves the FIFO at a frame boundary (idle or end of last stop bit).
    always_comb begin
        stop_hold = two_stop_l && !stopcnt;
        load      = baud_tick && !empty && (state == IDLE || (state == STOP && !stop_hold));
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tx         <= 1'b1;
            done       <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            stopcnt    <= 1'b0;
            two_stop_l <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_l      <= 1'b0;
`endif
        end else if (rst) begin
            tx         <= 1'b1;
            done       <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            stopcnt    <= 1'b0;
            two_stop_l <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_l      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (baud_tick) begin
                case (state)
                    START: begin
                        tx     <= shreg[0];
                        bitcnt <= '0;
                    end
                    DATA: begin
                        if (bitcnt != LAST_BIT) begin
                            shreg  <= shreg >> 1;
                            tx     <= shreg[1];
                            bitcnt <= bitcnt + CNT_W'(1);
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx <= par_l;
`else
                            tx <= 1'b1;
`endif
                            stopcnt <= 1'b0;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        tx      <= 1'b1;
                        stopcnt <= 1'b0;
                    end
`endif
                    STOP: begin
                        if (stop_hold) stopcnt <= 1'b1;
                        else           done    <= 1'b1;
                    end
                    default: ;
                endcase
                // Config is sampled per word so mid-frame changes only reach the next frame.
                if (load) begin
                    shreg      <= rdata;
                    two_stop_l <= cfg_two_stop;
`ifdef UART_TX_PARITY_EN
                    par_l      <= par_calc(DATA_W_MAX'(rdata), cfg_par_odd);
`endif
                    tx         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: vector table, scoreboard of expected line bits, corner sequences.
module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       arst_n, rst, baud_tick, s_valid, s_ready;
    logic [7:0] s_data;
    logic       cfg_two_stop, cfg_par_odd;
    logic       tx, busy, done;
    logic [2:0] fifo_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_W(8), .DEPTH(4)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .cfg_two_stop(cfg_two_stop),
        .cfg_par_odd (cfg_par_odd),
        .tx          (tx),
        .busy        (busy),
        .done        (done),
        .fifo_level  (fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: expected line level at each tick, appended when a word is accepted.
    logic exp_q[$];
    logic txlog[$];
    int   busy_n = 0;
    int   done_n = 0;

    function automatic void push_frame(input logic [7:0] d, input logic ts, input logic po);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back((^d) ^ po);
`else
        if (po === 1'bx) exp_q.push_back(1'b0);
`endif
        exp_q.push_back(1'b1);
        if (ts) exp_q.push_back(1'b1);
    endfunction

    logic       m_tick, m_push, m_rst, m_arst, m_ts, m_po, m_exp;
    logic [7:0] m_d;
    logic       prev_tx = 1'b1;
    logic       prev_busy = 1'b0;

    always @(posedge clk) begin
        m_tick = baud_tick; m_push = s_valid && s_ready; m_rst = rst; m_arst = arst_n;
        m_d = s_data; m_ts = cfg_two_stop; m_po = cfg_par_odd;
        #1;
        if (!m_arst || m_rst) begin
            exp_q.delete();
        end else begin
            if (m_tick) begin
                m_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
                chk("tx_bit", tx, m_exp);
                txlog.push_back(tx);
                if (busy) busy_n++;
            end else if (arst_n) begin
                chk("tx_hold", tx, prev_tx);
                chk("busy_hold", busy, prev_busy);
            end
            if (m_push) push_frame(m_d, m_ts, m_po);
        end
        if (done) done_n++;
        prev_tx = tx;
        prev_busy = busy;
    end

    task automatic baud(input int n);
        repeat (n) begin
            @(negedge clk); baud_tick = 1'b1;
            @(negedge clk); baud_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk); s_valid = 1'b1; s_data = d;
        @(negedge clk); s_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < 100) begin
            baud(1);
            k++;
        end
        chk("drain_timeout", (k < 100), 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ts;
        logic       po;
        logic       par;
        int         len;
    } vec_t;

    vec_t tbl[6];
    logic a5_seq[9];
    int   d0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10};
        tbl[1] = '{8'h07, 1'b0, 1'b0, 1'b1, 10};
        tbl[2] = '{8'h07, 1'b0, 1'b1, 1'b0, 10};
        tbl[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 11};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 10};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
        a5_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        arst_n = 1'b0; rst = 1'b0; baud_tick = 1'b0; s_valid = 1'b0; s_data = '0;
        cfg_two_stop = 1'b0; cfg_par_odd = 1'b0;
        #12;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", s_ready, 1);
        @(negedge clk); arst_n = 1'b1;
        baud(2);

        // Single frames across data/config patterns
        for (int i = 0; i < 6; i++) begin
            cfg_two_stop = tbl[i].ts;
            cfg_par_odd  = tbl[i].po;
            txlog.delete(); busy_n = 0; d0 = done_n;
            push(tbl[i].data);
            drain();
            chk("frame_len", busy_n, tbl[i].len + P);
            chk("done_cnt", done_n - d0, 1);
            chk("stop_bit", txlog[9 + P], 1);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", txlog[9], tbl[i].par);
`endif
            if (i == 0)
                for (int b = 0; b < 9; b++) chk("a5_seq", txlog[b], a5_seq[b]);
        end

        // Push coinciding with an idle tick is stored, not popped; then push+pop same cycle
        cfg_two_stop = 1'b0; cfg_par_odd = 1'b0; d0 = done_n;
        @(negedge clk); s_valid = 1'b1; s_data = 8'h3C; baud_tick = 1'b1;
        @(negedge clk); s_valid = 1'b0; baud_tick = 1'b0;
        chk("same_tick_busy", busy, 0);
        chk("same_tick_level", fifo_level, 1);
        @(negedge clk); s_valid = 1'b1; s_data = 8'hC3; baud_tick = 1'b1;
        @(negedge clk); s_valid = 1'b0; baud_tick = 1'b0;
        chk("push_pop_level", fifo_level, 1);
        chk("push_pop_busy", busy, 1);
        drain();
        chk("push_pop_done", done_n - d0, 2);

        // Fill the FIFO with ticks held off, then release for back-to-back frames
        d0 = done_n; busy_n = 0;
        for (int k = 0; k < 5; k++) begin
            push(8'(8'h11 * (k + 1)));
            chk("fill_level", fifo_level, (k < 4) ? k + 1 : 4);
            chk("fill_ready", s_ready, (k < 3) ? 1 : 0);
        end
        drain();
        chk("fill_done", done_n - d0, 4);
        chk("fill_busy_ticks", busy_n, 4 * (10 + P));
        chk("fill_sb_empty", exp_q.size(), 0);

        // Two stop bits; toggling the config mid-frame only affects the next word
        cfg_two_stop = 1'b1; txlog.delete(); busy_n = 0;
        push(8'h3C);
        baud(4);
        cfg_two_stop = 1'b0;
        push(8'hC3);
        drain();
        chk("two_stop_a", txlog[9 + P], 1);
        chk("two_stop_b", txlog[10 + P], 1);
        chk("next_start", txlog[11 + P], 0);
        chk("two_stop_ticks", busy_n, 21 + 2 * P);

        // Synchronous clear during data bit 3 with two words queued
        push(8'hF0); push(8'h11); push(8'h22);
        baud(5);
        chk("pre_rst_tx", tx, 0);
        d0 = done_n;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("srst_tx", tx, 1);
        chk("srst_busy", busy, 0);
        chk("srst_level", fifo_level, 0);
        chk("srst_ready", s_ready, 1);
        baud(15);
        chk("srst_no_done", done_n - d0, 0);

        // Asynchronous reset between edges mid-frame
        push(8'h00);
        baud(4);
        chk("pre_arst_tx", tx, 0);
        @(negedge clk); #2; arst_n = 1'b0; exp_q.delete();
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_busy", busy, 0);
        chk("arst_level", fifo_level, 0);
        @(negedge clk); @(negedge clk); arst_n = 1'b1;
        d0 = done_n; busy_n = 0;
        push(8'h3C);
        drain();
        chk("arst_resume_done", done_n - d0, 1);
        chk("arst_resume_len", busy_n, 10 + P);
        chk("arst_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
